vreg_dump_scheduler: RTL and testbench
======================================

VREG_DUMP_SCHEDULER -- requirements
Module: vreg_dump_scheduler

Interface
REQ-001 The block SHALL have parameter VLEN, default 2048, giving the bits per register segment; it must match the DPI dump sink.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester beat valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester beat accept.
REQ-007 The block SHALL have port req_addr, input, NREQ*8 bits: register address; requester i occupies [i*8+:8].
REQ-008 The block SHALL have port req_data, input, NREQ*VLEN bits: beat payload; requester i occupies [i*VLEN+:VLEN].
REQ-009 The block SHALL have port dump_en, output, 1 bit: one-cycle call strobe to the DPI dump sink.
REQ-010 The block SHALL have port dump_addr, output, 8 bits: register address of the dumped group.
REQ-011 The block SHALL have port dump_data, output, 8*VLEN bits: segment k occupies [k*VLEN+:VLEN].
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port grant_id, output, 3 bits: index of the current owner (valid while busy).
REQ-014 The block SHALL have port addr_err, output, 1 bit: sticky flag for an address mismatch within a group.

Function
REQ-015 The block SHALL use an FSM with states IDLE, COLLECT and FIRE.
REQ-016 A group SHALL be exactly 8 beats; beat k is stored in staging segment k.
REQ-017 IDLE: if any req_valid is high, the block SHALL select the owner by round-robin, starting the search at rr_ptr, and go to COLLECT at the next edge with beat_cnt=0; otherwise it stays in IDLE.
REQ-018 req_ready SHALL be all zeros in IDLE and FIRE.
REQ-019 COLLECT: req_ready[grant_id] SHALL equal 1 and all other req_ready bits 0; non-owner requests are ignored.
REQ-020 COLLECT handshake (req_valid[grant_id] and req_ready[grant_id] both high): the block SHALL store req_data in segment beat_cnt and increment beat_cnt.
REQ-021 COLLECT, beat 0: the block SHALL latch req_addr[grant_id] into dump_addr.
REQ-022 COLLECT, beats 1..7: if req_addr differs from the latched address, the block SHALL set addr_err; the data is still stored and dump_addr is unchanged.
REQ-023 The owner SHALL be locked for the whole group; a valid-low gap holds the current state and beat_cnt with no timeout.
REQ-024 The handshake on beat 7 SHALL move the FSM to FIRE.
REQ-025 FIRE: dump_en SHALL be 1 for exactly one cycle with stable dump_addr and dump_data.
REQ-026 Leaving FIRE: the block SHALL set rr_ptr = (grant_id+1) mod NREQ and go to IDLE.
REQ-027 dump_en SHALL be 0 in every state other than FIRE.
REQ-028 Minimum latency: with valid held high, dump_en SHALL assert in the 10th cycle after the first valid is sampled in IDLE (1 IDLE + 8 COLLECT + 1 FIRE).
REQ-029 Back-to-back groups SHALL have a throughput of one group per 10 cycles.
REQ-030 dump_data and dump_addr SHALL hold their value after FIRE until overwritten by the next group.
REQ-031 Simultaneous requests in IDLE SHALL be granted to the first requester at or after rr_ptr, wrapping from NREQ-1 to 0.
REQ-032 Requests arriving during COLLECT or FIRE SHALL wait and are considered in the next IDLE.
REQ-033 beat_cnt SHALL be 3 bits, saturate the group at 7, and never wrap within a group.

Reset
REQ-034 Reset assertion SHALL take effect immediately, independent of clk.
REQ-035 On reset: state=IDLE, beat_cnt=0, rr_ptr=0, grant_id=0.
REQ-036 On reset: dump_en=0, req_ready=0, busy=0, addr_err=0.
REQ-037 On reset: dump_addr=0 and dump_data=0.
REQ-038 Reset in the middle of a group SHALL discard the partial group, and no dump_en SHALL be emitted for it.
REQ-039 After reset deasserts, the first grant SHALL follow REQ-017 from rr_ptr=0.

Verification
REQ-040 Single group: requester 1 holds valid, addr=0x05, data=k+1 on beat k -> dump_en one pulse at cycle 10, dump_addr=0x05, segment k = k+1, addr_err=0.
REQ-041 Contention: requesters 0 and 2 both valid from reset release -> groups for 0 then 2; dump_en pulses at cycles 10 and 20; grant_id sequence 0,2.
REQ-042 Round-robin wrap: rr_ptr=3 (NREQ=4), requesters 0 and 3 valid -> 3 is granted before 0.
REQ-043 Stall: owner drops valid for 5 cycles after beat 3 -> dump_en at cycle 15; req_ready stays high for the owner only; data intact.
REQ-044 Address mismatch: beat 4 carries addr 0x06 against 0x05 -> addr_err=1 until reset, dump_addr=0x05, dump still fires.
REQ-045 Reset mid-group: reset asserted after beat 5 -> no dump_en; all outputs zero immediately; the next group completes normally.

Source files
------------

// File: rtl/vreg_dump_scheduler.sv
// vreg_dump_scheduler: collects 8-beat register groups from NREQ requesters
// under round-robin arbitration and fires a one-cycle dump strobe per group.
module vreg_dump_scheduler #(
  parameter int VLEN = 2048,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*8-1:0]      req_addr,
  input  logic [NREQ*VLEN-1:0]   req_data,
  output logic                   dump_en,
  output logic [7:0]             dump_addr,
  output logic [8*VLEN-1:0]      dump_data,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   addr_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FIRE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         beat_cnt_q, beat_cnt_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [7:0]         dump_addr_q, dump_addr_d;
  logic [8*VLEN-1:0]  dump_data_q, dump_data_d;
  logic               addr_err_q, addr_err_d;

  logic [NREQ-1:0]    owner_oh;
  logic               owner_valid;
  logic [7:0]         owner_addr;
  logic [VLEN-1:0]    owner_data;
  logic               pick_found;
  logic [2:0]         pick_id;

  // Decode the locked owner into a one-hot mask and mux out its beat fields
  always_comb begin
    owner_oh    = '0;
    owner_valid = 1'b0;
    owner_addr  = '0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 3'(i)) begin
        owner_oh[i] = 1'b1;
        owner_valid = req_valid[i];
        owner_addr  = req_addr[i*8 +: 8];
        owner_data  = req_data[i*VLEN +: VLEN];
      end
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!pick_found && req_valid[j] && (j == ((int'(rr_ptr_q) + i) % NREQ))) begin
          pick_found = 1'b1;
          pick_id    = 3'(j);
        end
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, stage beats in COLLECT, advance pointer in FIRE
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    addr_err_d  = addr_err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_id;
          beat_cnt_d = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (owner_valid) begin
          dump_data_d[int'(beat_cnt_q)*VLEN +: VLEN] = owner_data;
          if (beat_cnt_q == 3'd0) begin
            dump_addr_d = owner_addr;
          end else if (owner_addr != dump_addr_q) begin
            addr_err_d = 1'b1;
          end
          if (beat_cnt_q == 3'd7) begin
            state_d = FIRE;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      FIRE: begin
        rr_ptr_d = (grant_q == 3'(NREQ-1)) ? 3'd0 : grant_q + 3'd1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a partial group is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign req_ready = (state_q == COLLECT) ? owner_oh : '0;
  assign dump_en   = (state_q == FIRE);
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign dump_addr = dump_addr_q;
  assign dump_data = dump_data_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_vreg_dump_scheduler.sv
// Directed self-checking bench for vreg_dump_scheduler (VLEN reduced for readability).
module tb_vreg_dump_scheduler;

  localparam int VLEN = 32;
  localparam int NREQ = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*8-1:0]     req_addr;
  logic [NREQ*VLEN-1:0]  req_data;
  logic                  dump_en;
  logic [7:0]            dump_addr;
  logic [8*VLEN-1:0]     dump_data;
  logic                  busy;
  logic [2:0]            grant_id;
  logic                  addr_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  vreg_dump_scheduler #(.VLEN(VLEN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .dump_en   (dump_en),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .addr_err  (addr_err)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Give every requester distinctive junk so a wrong capture is visible
  task automatic set_background();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*8 +: 8]       = 8'hE0 | 8'(i);
      req_data[i*VLEN +: VLEN] = 32'hDEAD_0000 | 32'(i);
    end
  endtask

  // Drive one group from 'owner' starting at an IDLE cycle, checking every cycle
  // up to and including FIRE. Beat k carries data k+1+salt. A stall of stall_len
  // cycles is inserted before beat stall_beat; beat bad_beat carries bad_addr.
  // abort_beat >= 0 returns before that beat is driven (valid left high).
  task automatic applyStimulus(input int owner, input logic [7:0] addr, input int salt,
                               input int stall_beat, input int stall_len,
                               input int bad_beat, input logic [7:0] bad_addr,
                               input logic [NREQ-1:0] extra_valid, input logic exp_err,
                               input int abort_beat);
    logic [NREQ-1:0] own;
    int beat;
    int gap;
    int fire_cycle;
    own        = NREQ'(1) << owner;
    beat       = 0;
    gap        = 0;
    fire_cycle = 10 + stall_len;
    for (int c = 1; c <= fire_cycle; c++) begin
      if (c == 1) begin
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_ready", 64'(req_ready), 64'd0);
        checkOutput("idle_dump_en", 64'(dump_en), 64'd0);
        req_valid = extra_valid | own;
        req_addr[owner*8 +: 8] = addr;
      end else if (c < fire_cycle) begin
        if (beat == abort_beat) return;
        checkOutput("collect_busy", 64'(busy), 64'd1);
        checkOutput("collect_grant", 64'(grant_id), 64'(owner));
        checkOutput("collect_ready", 64'(req_ready), 64'(own));
        checkOutput("collect_dump_en", 64'(dump_en), 64'd0);
        if (beat == stall_beat && gap < stall_len) begin
          req_valid = req_valid & ~own;
          gap++;
        end else begin
          req_valid = req_valid | own;
          req_addr[owner*8 +: 8]       = (beat == bad_beat) ? bad_addr : addr;
          req_data[owner*VLEN +: VLEN] = VLEN'(beat + 1 + salt);
          beat++;
        end
      end else begin
        checkOutput("fire_dump_en", 64'(dump_en), 64'd1);
        checkOutput("fire_busy", 64'(busy), 64'd1);
        checkOutput("fire_grant", 64'(grant_id), 64'(owner));
        checkOutput("fire_ready", 64'(req_ready), 64'd0);
        checkOutput("fire_addr", 64'(dump_addr), 64'(addr));
        checkOutput("fire_addr_err", 64'(addr_err), 64'(exp_err));
        for (int k = 0; k < 8; k++) begin
          checkOutput("fire_segment", 64'(dump_data[k*VLEN +: VLEN]), 64'(k + 1 + salt));
        end
        req_valid = extra_valid & ~own;
      end
      next_cycle();
    end
    checkOutput("post_dump_en", 64'(dump_en), 64'd0);
    checkOutput("post_addr_hold", 64'(dump_addr), 64'(addr));
    checkOutput("post_data_hold", 64'(dump_data[7*VLEN +: VLEN]), 64'(8 + salt));
  endtask

  // Directed sequence; each group leaves rr_ptr where the next one expects it
  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    set_background();
    @(negedge clk);
    next_cycle();

    checkOutput("rst_dump_en", 64'(dump_en), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_addr_err", 64'(addr_err), 64'd0);
    checkOutput("rst_grant", 64'(grant_id), 64'd0);
    checkOutput("rst_dump_addr", 64'(dump_addr), 64'd0);
    checkOutput("rst_dump_data", 64'(dump_data[0 +: VLEN]), 64'd0);
    reset = 1'b0;
    next_cycle();

    // Contention from reset release: 0 then 2, dumps at cycles 10 and 20
    applyStimulus(0, 8'h11, 16, -1, 0, -1, 8'h00, 4'b0101, 1'b0, -1);
    applyStimulus(2, 8'h22, 32, -1, 0, -1, 8'h00, 4'b0000, 1'b0, -1);

    // rr_ptr is now 3: requester 3 wins over 0, then 0
    applyStimulus(3, 8'h33, 48, -1, 0, -1, 8'h00, 4'b1001, 1'b0, -1);
    applyStimulus(0, 8'h44, 64, -1, 0, -1, 8'h00, 4'b0000, 1'b0, -1);

    // Single group from requester 1, address 0x05, data k+1
    applyStimulus(1, 8'h05, 0, -1, 0, -1, 8'h00, 4'b0000, 1'b0, -1);

    // Five-cycle stall after beat 3: dump in cycle 15
    applyStimulus(2, 8'h07, 80, 4, 5, -1, 8'h00, 4'b0000, 1'b0, -1);

    // Address mismatch on beat 4: sticky error, dump still fires with 0x05
    applyStimulus(3, 8'h05, 96, -1, 0, 4, 8'h06, 4'b0000, 1'b1, -1);
    for (int i = 0; i < 3; i++) next_cycle();
    checkOutput("err_sticky", 64'(addr_err), 64'd1);
    checkOutput("err_addr_kept", 64'(dump_addr), 64'h05);

    // Reset after beat 5 of a group: outputs clear at once, no dump follows
    applyStimulus(1, 8'h09, 112, -1, 0, -1, 8'h00, 4'b0000, 1'b1, 6);
    req_valid = '0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_dump_en", 64'(dump_en), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_ready", 64'(req_ready), 64'd0);
    checkOutput("async_addr_err", 64'(addr_err), 64'd0);
    checkOutput("async_grant", 64'(grant_id), 64'd0);
    checkOutput("async_dump_addr", 64'(dump_addr), 64'd0);
    checkOutput("async_seg0", 64'(dump_data[0 +: VLEN]), 64'd0);
    checkOutput("async_seg5", 64'(dump_data[5*VLEN +: VLEN]), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_hold_dump_en", 64'(dump_en), 64'd0);
      next_cycle();
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checkOutput("after_rst_dump_en", 64'(dump_en), 64'd0);
      checkOutput("after_rst_busy", 64'(busy), 64'd0);
      next_cycle();
    end

    // Arbitration restarts from rr_ptr=0: 1 before 3
    applyStimulus(1, 8'h0A, 128, -1, 0, -1, 8'h00, 4'b1010, 1'b0, -1);
    applyStimulus(3, 8'h0B, 144, -1, 0, -1, 8'h00, 4'b0000, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
